// File: rtl/vram_line_reader_pkg.sv
// vram_line_reader_pkg
// Shared video definitions: the VRAM read-port geometry, the output pixel
// width, the default run/FIFO sizing and the line reader state encoding.
package vram_line_reader_pkg;

  localparam int VRAM_ADDR_WIDTH    = 12;
  localparam int VRAM_DATA_WIDTH    = 32;
  localparam int PIXEL_WIDTH        = 16;
  localparam int READER_COUNT_WIDTH = 9;
  localparam int READER_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } readerState_e;

endpackage

// File: rtl/vram_line_reader_if.sv
// vram_line_reader_if
// Bundles the line reader's command, RAM read port and pixel stream.
//   command : start, baseAddr, count (scheduler -> reader); busy, done (reader -> scheduler)
//   RAM     : ramRd, ramAddr (reader -> RAM); ramDout (RAM -> reader, one cycle after ramRd)
//   pixels  : pixelValid, pixelBits (reader -> renderer); pixelReady (renderer -> reader)
// Modports: slave = the reader itself, master = everything around it.
interface vram_line_reader_if
  import vram_line_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = VRAM_DATA_WIDTH,
  parameter int OUT_WIDTH   = PIXEL_WIDTH,
  parameter int COUNT_WIDTH = READER_COUNT_WIDTH
);

  logic                   start;
  logic [ADDR_WIDTH-1:0]  baseAddr;
  logic [COUNT_WIDTH-1:0] count;
  logic                   busy;
  logic                   done;
  logic                   ramRd;
  logic [ADDR_WIDTH-1:0]  ramAddr;
  logic [DATA_WIDTH-1:0]  ramDout;
  logic                   pixelValid;
  logic                   pixelReady;
  logic [OUT_WIDTH-1:0]   pixelBits;

  modport slave (
    input  start, baseAddr, count, ramDout, pixelReady,
    output busy, done, ramRd, ramAddr, pixelValid, pixelBits
  );

  modport master (
    output start, baseAddr, count, ramDout, pixelReady,
    input  busy, done, ramRd, ramAddr, pixelValid, pixelBits
  );

endinterface

// File: rtl/vram_line_reader_sync_word_fifo.sv
// sync_word_fifo
// Small single-clock word FIFO with a registered head output, shared by the
// layer fetchers.
//   clock    : rising-edge clock
//   reset    : asynchronous, active-low; empties the FIFO and clears head
//   push     : write pushData this cycle (caller guarantees space)
//   pushData : word to write
//   pop      : discard the head word (ignored when empty)
//   count    : number of stored words, 0..DEPTH
//   head     : oldest word, valid whenever count != 0
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] rdPtrNext;
  logic             popOk;

  assign popOk     = pop && (count != '0);
  assign rdPtrNext = rdPtr + 1'b1;

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + 1'b1;
      if (popOk) rdPtr <= rdPtr + 1'b1;

      case ({push, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Head tracks the oldest word: after a pop it is the next stored word,
      // unless the FIFO would otherwise be empty, in which case the word
      // being pushed falls straight through.
      if (popOk && count > CNT_W'(1))
        head <= mem[rdPtrNext];
      else if (push && ((count == '0) || (popOk && count == CNT_W'(1))))
        head <= pushData;
    end
  end

endmodule

// File: rtl/vram_line_reader.sv
// vram_line_reader
// Streams a run of consecutive 32-bit words out of the VRAM read port and
// hands them to the layer renderer as 16-bit halfwords, low half first.
//   clock : rising-edge clock
//   reset : asynchronous, active-low; aborts any run without a done pulse
//   io    : slave view of vram_line_reader_if (command, RAM port, pixels)
// The RAM returns data one cycle after ramRd; reads are only issued when
// the FIFO has room for every word already requested, so the returning
// word can always be written without a full check.
module vram_line_reader
  import vram_line_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = VRAM_DATA_WIDTH,   // must be 2*OUT_WIDTH
  parameter int OUT_WIDTH   = PIXEL_WIDTH,
  parameter int COUNT_WIDTH = READER_COUNT_WIDTH,
  parameter int FIFO_DEPTH  = READER_FIFO_DEPTH  // power of two, >= 2
) (
  input  logic               clock,
  input  logic               reset,
  vram_line_reader_if.slave  io
);

  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  readerState_e           stateReg;
  readerState_e           stateNext;
  logic [ADDR_WIDTH-1:0]  addrReg;
  logic [COUNT_WIDTH-1:0] issueLeftReg;
  logic [COUNT_WIDTH-1:0] popLeftReg;
  logic                   inFlightReg;
  logic                   halfReg;
  logic                   doneReg;
  logic                   doneNext;

  logic [FIFO_CNT_W-1:0]  fifoCount;
  logic [DATA_WIDTH-1:0]  fifoHead;

  logic                   credit;
  logic                   issue;
  logic                   handshake;
  logic                   popWord;
  logic                   lastPop;

  // A read may go out only if the stored words plus the one still coming
  // back from the RAM leave a free slot.
  assign credit    = (fifoCount + FIFO_CNT_W'(inFlightReg)) < FIFO_CNT_W'(FIFO_DEPTH);
  assign issue     = (stateReg == FETCH) && (issueLeftReg != '0) && credit;
  assign handshake = io.pixelValid && io.pixelReady;
  assign popWord   = handshake && halfReg;
  assign lastPop   = popWord && (popLeftReg == COUNT_WIDTH'(1));

  assign io.busy       = (stateReg != IDLE);
  assign io.done       = doneReg;
  assign io.ramRd      = issue;
  assign io.ramAddr    = addrReg;
  assign io.pixelValid = (fifoCount != '0);
  assign io.pixelBits  = halfReg ? fifoHead[DATA_WIDTH-1:OUT_WIDTH] : fifoHead[OUT_WIDTH-1:0];

  sync_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) wordFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (inFlightReg),
    .pushData (io.ramDout),
    .pop      (popWord),
    .count    (fifoCount),
    .head     (fifoHead)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      doneReg  <= doneNext;
    end
  end

  // done is registered so that on a normal run it coincides with the return
  // to IDLE; a zero-length run raises it on its single DRAIN cycle instead.
  always_comb begin
    stateNext = stateReg;
    doneNext  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (io.start) begin
          stateNext = (io.count == '0) ? DRAIN : FETCH;
          doneNext  = (io.count == '0);
        end
      end
      FETCH: begin
        if (issue && issueLeftReg == COUNT_WIDTH'(1)) stateNext = DRAIN;
      end
      DRAIN: begin
        doneNext = lastPop;
        if (lastPop || (popLeftReg == '0 && !inFlightReg)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addrReg      <= '0;
      issueLeftReg <= '0;
      popLeftReg   <= '0;
      inFlightReg  <= 1'b0;
      halfReg      <= 1'b0;
    end else begin
      inFlightReg <= issue;
      if (stateReg == IDLE && io.start) begin
        addrReg      <= io.baseAddr;
        issueLeftReg <= io.count;
        popLeftReg   <= io.count;
      end else begin
        if (issue) begin
          addrReg      <= addrReg + 1'b1;   // wraps at the top of the RAM
          issueLeftReg <= issueLeftReg - 1'b1;
        end
        if (popWord) popLeftReg <= popLeftReg - 1'b1;
      end
      if (handshake) halfReg <= ~halfReg;
    end
  end

endmodule

// File: tb/tb_vram_line_reader.sv
// tb_vram_line_reader
// Directed bench for vram_line_reader: a behavioural one-cycle-latency RAM
// returns {16'hA000+addr, 16'hB000+addr} for every word address, a monitor
// logs read addresses, accepted halfwords and done pulses, and a single
// initial block walks through the directed scenarios.
module tb_vram_line_reader;

  logic clock;
  logic reset;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  logic [11:0] readQ[$];
  logic [15:0] pixQ[$];

  vram_line_reader_if #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .OUT_WIDTH(16), .COUNT_WIDTH(9)
  ) io ();

  vram_line_reader #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .OUT_WIDTH(16), .COUNT_WIDTH(9), .FIFO_DEPTH(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ramWord(input logic [11:0] a);
    return {16'hA000 + {4'h0, a}, 16'hB000 + {4'h0, a}};
  endfunction

  function automatic logic [15:0] expLo(input logic [11:0] a);
    return 16'hB000 + {4'h0, a};
  endfunction

  function automatic logic [15:0] expHi(input logic [11:0] a);
    return 16'hA000 + {4'h0, a};
  endfunction

  // RAM model: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    if (io.ramRd) io.ramDout <= ramWord(io.ramAddr);
  end

  always @(posedge clock) begin
    if (reset) begin
      if (io.ramRd) readQ.push_back(io.ramAddr);
      if (io.pixelValid && io.pixelReady) pixQ.push_back(io.pixelBits);
      if (io.done) doneCnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of T+1.
  task automatic doStart(input logic [11:0] b, input logic [8:0] c);
    io.start = 1'b1;
    io.baseAddr = b;
    io.count = c;
    @(negedge clock);
    io.start = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int n);
    n = 0;
    while (io.done !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, 32'(io.done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(io.busy), 32'd0);
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(io.done), 32'd0);
  endtask

  task automatic checkRun(input string tag, input logic [11:0] b, input int words);
    check({tag, "_halfword_count"}, 32'(pixQ.size()), 32'(2 * words));
    for (int k = 0; k < words && 2 * k + 1 < pixQ.size(); k++) begin
      check($sformatf("%s_lo%0d", tag, k), 32'(pixQ[2*k]), 32'(expLo(b + 12'(k))));
      check($sformatf("%s_hi%0d", tag, k), 32'(pixQ[2*k+1]), 32'(expHi(b + 12'(k))));
    end
  endtask

  initial begin
    int n;
    int d0;
    logic [15:0] held;

    io.start = 1'b0;
    io.baseAddr = '0;
    io.count = '0;
    io.pixelReady = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_done", 32'(io.done), 32'd0);
    check("rst_ramRd", 32'(io.ramRd), 32'd0);
    check("rst_ramAddr", 32'(io.ramAddr), 32'd0);
    check("rst_valid", 32'(io.pixelValid), 32'd0);
    check("rst_bits", 32'(io.pixelBits), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    $display("step reset: released");

    // Basic run with latency checks.
    readQ.delete(); pixQ.delete(); d0 = doneCnt;
    doStart(12'h010, 9'd3);
    check("basic_busy_T1", 32'(io.busy), 32'd1);
    check("basic_ramRd_T1", 32'(io.ramRd), 32'd1);
    check("basic_ramAddr_T1", 32'(io.ramAddr), 32'h010);
    @(negedge clock);
    check("basic_valid_T2", 32'(io.pixelValid), 32'd0);
    @(negedge clock);
    check("basic_valid_T3", 32'(io.pixelValid), 32'd1);
    check("basic_bits_T3", 32'(io.pixelBits), 32'hB010);
    waitDone("basic", n);
    check("basic_done_latency", 32'(n), 32'd6);
    checkRun("basic", 12'h010, 3);
    check("basic_reads", 32'(readQ.size()), 32'd3);
    check("basic_done_count", 32'(doneCnt - d0), 32'd1);
    $display("step basic: %0d halfwords, %0d reads", pixQ.size(), readQ.size());

    // Address wrap at the top of the RAM.
    readQ.delete(); pixQ.delete();
    doStart(12'hFFE, 9'd4);
    waitDone("wrap", n);
    check("wrap_reads", 32'(readQ.size()), 32'd4);
    if (readQ.size() == 4) begin
      check("wrap_addr0", 32'(readQ[0]), 32'hFFE);
      check("wrap_addr1", 32'(readQ[1]), 32'hFFF);
      check("wrap_addr2", 32'(readQ[2]), 32'h000);
      check("wrap_addr3", 32'(readQ[3]), 32'h001);
    end
    checkRun("wrap", 12'hFFE, 4);
    $display("step wrap: %0d reads", readQ.size());

    // Backpressure: hold ready low for 20 cycles.
    readQ.delete(); pixQ.delete();
    io.pixelReady = 1'b0;
    doStart(12'h100, 9'd8);
    repeat (2) @(negedge clock);
    held = io.pixelBits;
    check("bp_first_bits", 32'(held), 32'hB100);
    repeat (17) @(negedge clock);
    check("bp_valid_held", 32'(io.pixelValid), 32'd1);
    check("bp_bits_stable", 32'(io.pixelBits), 32'(held));
    check("bp_reads_bounded", 32'(readQ.size() <= 4), 32'd1);
    io.pixelReady = 1'b1;
    waitDone("bp", n);
    checkRun("bp", 12'h100, 8);
    check("bp_reads_total", 32'(readQ.size()), 32'd8);
    $display("step backpressure: %0d halfwords", pixQ.size());

    // Zero-length run.
    readQ.delete(); pixQ.delete(); d0 = doneCnt;
    doStart(12'h055, 9'd0);
    check("zero_done_T1", 32'(io.done), 32'd1);
    check("zero_busy_T1", 32'(io.busy), 32'd1);
    @(negedge clock);
    check("zero_done_T2", 32'(io.done), 32'd0);
    check("zero_busy_T2", 32'(io.busy), 32'd0);
    check("zero_reads", 32'(readQ.size()), 32'd0);
    check("zero_done_count", 32'(doneCnt - d0), 32'd1);
    $display("step zero: done pulses %0d", doneCnt - d0);

    // Start while busy is ignored.
    readQ.delete(); pixQ.delete(); d0 = doneCnt;
    doStart(12'h200, 9'd4);
    @(negedge clock);
    io.start = 1'b1; io.baseAddr = 12'h300; io.count = 9'd2;
    @(negedge clock);
    io.start = 1'b0;
    waitDone("busy", n);
    checkRun("busy", 12'h200, 4);
    check("busy_reads", 32'(readQ.size()), 32'd4);
    check("busy_done_count", 32'(doneCnt - d0), 32'd1);
    @(negedge clock);
    check("busy_stays_idle", 32'(io.busy), 32'd0);
    $display("step start-while-busy: %0d halfwords", pixQ.size());

    // Reset in the middle of a 16-word run.
    readQ.delete(); pixQ.delete(); d0 = doneCnt;
    doStart(12'h040, 9'd16);
    n = 0;
    while (pixQ.size() < 5 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("mid_reached5", 32'(pixQ.size() >= 5), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_busy", 32'(io.busy), 32'd0);
    check("mid_done", 32'(io.done), 32'd0);
    check("mid_ramRd", 32'(io.ramRd), 32'd0);
    check("mid_ramAddr", 32'(io.ramAddr), 32'd0);
    check("mid_valid", 32'(io.pixelValid), 32'd0);
    check("mid_bits", 32'(io.pixelBits), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("mid_valid_after", 32'(io.pixelValid), 32'd0);
    check("mid_no_done", 32'(doneCnt - d0), 32'd0);
    readQ.delete(); pixQ.delete();
    doStart(12'h080, 9'd2);
    waitDone("fresh", n);
    checkRun("fresh", 12'h080, 2);
    check("fresh_reads", 32'(readQ.size()), 32'd2);
    $display("step reset-mid-run: fresh run %0d halfwords", pixQ.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
